// File: rtl/vip_is2vid_pkg.sv
// vip_is2vid_pkg: shared types and constants for the IS-to-video input path.
//   state_t       receive state machine encoding
//   PKT_VIDEO     Avalon-ST video packet type nibble
//   PKT_CTRL      Avalon-ST control packet type nibble
//   CTRL_NIBBLES  nibbles carried by a control packet (width, height, interlace)
package vip_is2vid_pkg;

  typedef enum logic [2:0] {
    WAIT_SOP,
    CTRL,
    VIDEO,
    DISCARD,
    ANC
  } state_t;

  localparam logic [3:0] PKT_VIDEO    = 4'd0;
  localparam logic [3:0] PKT_CTRL     = 4'd15;
  localparam int         CTRL_NIBBLES = 9;

endpackage

// File: rtl/vip_is2vid_av_st_input_if.sv
// vip_is2vid_av_st_input_if: Avalon-ST video beat bus, ready latency 1.
//   is_ready  sink -> source, registered ready
//   is_valid  beat valid
//   is_data   beat data (DATA_WIDTH)
//   is_sop    start of packet
//   is_eop    end of packet
// Modports: master = video source, slave = video sink.
interface vip_is2vid_av_st_input_if #(
  parameter int DATA_WIDTH = 20
);
  logic                  is_ready;
  logic                  is_valid;
  logic [DATA_WIDTH-1:0] is_data;
  logic                  is_sop;
  logic                  is_eop;

  modport master (input is_ready, output is_valid, is_data, is_sop, is_eop);
  modport slave  (output is_ready, input is_valid, is_data, is_sop, is_eop);
endinterface

// File: rtl/vip_is2vid_ctrl_decode.sv
// vip_is2vid_ctrl_decode: control packet decoder.
// Collects the 9 control nibbles into shadow registers and publishes them
// on eop once all nibbles have arrived.
//   is_clk, rst_n   clock, async active-low reset
//   hdr             control header beat accepted (restarts beat numbering)
//   beat            control data beat accepted
//   eop             eop of the current beat
//   lane_nib        low nibble of each symbol lane of the current beat
//   ctrl_width/height/interlace  last complete decode
//   ctrl_update     pulse: ctrl_* just loaded
//   ctrl_err        pulse: packet ended before nibble 8
module vip_is2vid_ctrl_decode
  import vip_is2vid_pkg::*;
#(
  parameter int P = 2
) (
  input  logic              is_clk,
  input  logic              rst_n,
  input  logic              hdr,
  input  logic              beat,
  input  logic              eop,
  input  logic [P-1:0][3:0] lane_nib,
  output logic [15:0]       ctrl_width,
  output logic [15:0]       ctrl_height,
  output logic [3:0]        ctrl_interlace,
  output logic              ctrl_update,
  output logic              ctrl_err
);
  // Data beat carrying nibble 8; any eop at or after it completes the packet.
  localparam int LAST_BEAT = (CTRL_NIBBLES + P - 1) / P;

  logic [3:0]                    beat_idx;  // 1-based number of the next data beat
  logic [CTRL_NIBBLES-1:0][3:0]  shadow, shadow_nxt;
  logic                          full;

  // Nibble k lives in data beat 1+k/P, lane k%P. Beats past LAST_BEAT match
  // no nibble and so are ignored.
  for (genvar k = 0; k < CTRL_NIBBLES; k++) begin : g_nib
    localparam logic [3:0] BEAT_NO = 4'(1 + k / P);
    assign shadow_nxt[k] = (beat && beat_idx == BEAT_NO) ? lane_nib[k % P] : shadow[k];
  end

  assign full = (beat_idx >= 4'(LAST_BEAT));

  always_ff @(posedge is_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx       <= '0;
      shadow         <= '0;
      ctrl_width     <= '0;
      ctrl_height    <= '0;
      ctrl_interlace <= '0;
      ctrl_update    <= 1'b0;
      ctrl_err       <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      ctrl_update <= beat && eop && full;
      // A header that is also eop carries no nibbles at all.
      ctrl_err    <= (hdr && eop) || (beat && eop && !full);
      if (hdr)
        beat_idx <= 4'd1;
      else if (beat && beat_idx != 4'hf)
        beat_idx <= beat_idx + 4'd1;
      if (beat && eop && full) begin
        ctrl_width     <= {shadow_nxt[0], shadow_nxt[1], shadow_nxt[2], shadow_nxt[3]};
        ctrl_height    <= {shadow_nxt[4], shadow_nxt[5], shadow_nxt[6], shadow_nxt[7]};
        ctrl_interlace <= shadow_nxt[8];
      end
    end
  end

endmodule

// File: rtl/vip_is2vid_av_st_input.sv
// vip_is2vid_av_st_input: Avalon-ST video sink feeding the IS-to-video FIFO.
// Decodes control packets, forwards video packets as {data, end_flag} words
// and checks received video size against the last decoded control packet.
//   is_clk, rst_n    clock, async active-low reset
//   enable           0 withholds ready
//   av (slave)       Avalon-ST beat bus, ready latency 1
//   almost_full      FIFO has fewer than 3 free words
//   wrreq, wrdata    FIFO write, one cycle after the accepted beat
//   ctrl_*           last decoded control values, ctrl_update pulse
//   ctrl_err         pulse: control packet too short
//   size_err         pulse: video packet size mismatch at eop
//   pkt_err          pulse: sop arrived mid-packet
// Build option: VIP_IS2VID_ANC_PASS_EN forwards ancillary packets to the
// FIFO; without it they are dropped.
module vip_is2vid_av_st_input
  import vip_is2vid_pkg::*;
#(
  parameter int FIFO_WIDTH                          = 21,
  parameter int DATA_WIDTH                          = 20,
  parameter int NUMBER_OF_COLOUR_PLANES_IN_PARALLEL = 2,
  parameter int BPS                                 = 10
) (
  input  logic                  is_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  vip_is2vid_av_st_input_if.slave av,
  input  logic                  almost_full,
  output logic                  wrreq,
  output logic [FIFO_WIDTH-1:0] wrdata,
  output logic [15:0]           ctrl_width,
  output logic [15:0]           ctrl_height,
  output logic [3:0]            ctrl_interlace,
  output logic                  ctrl_update,
  output logic                  ctrl_err,
  output logic                  size_err,
  output logic                  pkt_err
);
  localparam int P = NUMBER_OF_COLOUR_PLANES_IN_PARALLEL;

  state_t            state, state_nxt;
  logic              acc, sop_hdr, hdr_video, hdr_ctrl, hdr_anc;
  logic [3:0]        typ;
  logic [15:0]       samp_cnt, line_cnt, samp_nxt, line_nxt, samp_inc, line_tgt;
  logic              wr_nxt, size_err_nxt, pkt_err_nxt, ctrl_seen;
  logic [P-1:0][3:0] lane_nib;

  // Ready latency 1: the source only drives valid after seeing ready, so
  // every valid beat is accepted unconditionally.
  assign acc       = av.is_valid;
  assign sop_hdr   = acc && av.is_sop;
  assign typ       = av.is_data[3:0];
  assign hdr_video = (typ == PKT_VIDEO);
  assign hdr_ctrl  = (typ == PKT_CTRL);
`ifdef VIP_IS2VID_ANC_PASS_EN
  assign hdr_anc   = !hdr_video && !hdr_ctrl;
`else
  assign hdr_anc   = 1'b0;
`endif

  // Interlaced fields carry half the frame height.
  assign line_tgt = ctrl_interlace[3] ? {1'b0, ctrl_height[15:1]} : ctrl_height;

  for (genvar l = 0; l < P; l++) begin : g_lane
    assign lane_nib[l] = av.is_data[BPS*l +: 4];
  end

  always_ff @(posedge is_clk or negedge rst_n) begin
    if (!rst_n) av.is_ready <= 1'b0;
    else        av.is_ready <= enable && !almost_full;
  end

  // State register
  always_ff @(posedge is_clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOP;
    else        state <= state_nxt;
  end

  // Next state: any sop restarts decoding, whatever state we are in.
  always_comb begin
    state_nxt = state;
    if (sop_hdr) begin
      if (av.is_eop)      state_nxt = WAIT_SOP;
      else if (hdr_ctrl)  state_nxt = CTRL;
      else if (hdr_video) state_nxt = VIDEO;
      else if (hdr_anc)   state_nxt = ANC;
      else                state_nxt = DISCARD;
    end else if (acc && av.is_eop) begin
      state_nxt = WAIT_SOP;
    end
  end

  // Outputs: FIFO write, raster counters and error pulses.
  always_comb begin
    wr_nxt       = 1'b0;
    samp_nxt     = samp_cnt;
    line_nxt     = line_cnt;
    samp_inc     = samp_cnt + 16'(P);
    size_err_nxt = 1'b0;
    pkt_err_nxt  = sop_hdr && (state != WAIT_SOP);
    if (sop_hdr) begin
      wr_nxt   = hdr_video || hdr_anc;
      samp_nxt = '0;
      line_nxt = '0;
    end else if (acc) begin
      case (state)
        VIDEO: begin
          wr_nxt = 1'b1;
          if (samp_inc == ctrl_width) begin
            samp_nxt = '0;
            line_nxt = line_cnt + 16'd1;
          end else begin
            samp_nxt = samp_inc;
          end
          size_err_nxt = av.is_eop && ctrl_seen &&
                         ((samp_nxt != '0) || (line_nxt != line_tgt));
        end
        ANC:     wr_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge is_clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt  <= '0;
      line_cnt  <= '0;
      wrreq     <= 1'b0;
      wrdata    <= '0;
      size_err  <= 1'b0;
      pkt_err   <= 1'b0;
      ctrl_seen <= 1'b0;
    end else begin
      samp_cnt  <= samp_nxt;
      line_cnt  <= line_nxt;
      wrreq     <= wr_nxt;
      size_err  <= size_err_nxt;
      pkt_err   <= pkt_err_nxt;
      ctrl_seen <= ctrl_seen || ctrl_update;
      if (wr_nxt) wrdata <= {av.is_data, av.is_eop};
    end
  end

  vip_is2vid_ctrl_decode #(.P(P)) u_ctrl_decode (
    .is_clk         (is_clk),
    .rst_n          (rst_n),
    .hdr            (sop_hdr && hdr_ctrl),
    .beat           (acc && !av.is_sop && (state == CTRL)),
    .eop            (av.is_eop),
    .lane_nib       (lane_nib),
    .ctrl_width     (ctrl_width),
    .ctrl_height    (ctrl_height),
    .ctrl_interlace (ctrl_interlace),
    .ctrl_update    (ctrl_update),
    .ctrl_err       (ctrl_err)
  );

endmodule

// File: tb/tb_vip_is2vid_av_st_input.sv
// tb_vip_is2vid_av_st_input: table-driven bench for vip_is2vid_av_st_input
// (P=2, BPS=10). Each table row is one bus cycle plus the outputs expected
// one cycle later.
module tb_vip_is2vid_av_st_input;
  localparam int DW = 20, FW = 21, P = 2, BPS = 10;
`ifdef VIP_IS2VID_ANC_PASS_EN
  localparam bit ANC_ON = 1'b1;
`else
  localparam bit ANC_ON = 1'b0;
`endif

  logic          is_clk = 1'b0, rst_n = 1'b0, enable = 1'b0, almost_full = 1'b0;
  logic          wrreq, ctrl_update, ctrl_err, size_err, pkt_err;
  logic [FW-1:0] wrdata;
  logic [15:0]   ctrl_width, ctrl_height;
  logic [3:0]    ctrl_interlace;

  vip_is2vid_av_st_input_if #(.DATA_WIDTH(DW)) av ();

  vip_is2vid_av_st_input #(
    .FIFO_WIDTH(FW), .DATA_WIDTH(DW),
    .NUMBER_OF_COLOUR_PLANES_IN_PARALLEL(P), .BPS(BPS)
  ) dut (
    .is_clk(is_clk), .rst_n(rst_n), .enable(enable), .av(av),
    .almost_full(almost_full), .wrreq(wrreq), .wrdata(wrdata),
    .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
    .ctrl_interlace(ctrl_interlace), .ctrl_update(ctrl_update),
    .ctrl_err(ctrl_err), .size_err(size_err), .pkt_err(pkt_err)
  );

  always #5 is_clk = ~is_clk;

  typedef struct {
    logic          v, sop, eop;
    logic [DW-1:0] data;
    logic          wr, upd, cerr, serr, perr;
    logic [15:0]   w, h;
    logic [3:0]    il;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0, n_fail = 0;
  logic [15:0] cw = '0, ch = '0;
  logic [3:0]  cil = '0;

  // Lane 0 nibble a, lane 1 nibble b, filler in the other symbol bits.
  function automatic logic [DW-1:0] d(input logic [3:0] a, input logic [3:0] b);
    return {6'h15, b, 6'h2A, a};
  endfunction

  function automatic void add(input logic sop, input logic eop, input logic [3:0] a,
                              input logic [3:0] b, input logic wr, input logic upd,
                              input logic cerr, input logic serr, input logic perr);
    vec_t t;
    t.v = 1'b1; t.sop = sop; t.eop = eop; t.data = d(a, b);
    t.wr = wr; t.upd = upd; t.cerr = cerr; t.serr = serr; t.perr = perr;
    t.w = cw; t.h = ch; t.il = cil;
    vecs.push_back(t);
  endfunction

  // Video packet: header + nb data beats, size error expected at eop or not.
  function automatic void add_video(input int nb, input logic serr);
    add(1, 0, 4'h0, 4'h1, 1, 0, 0, 0, 0);
    for (int i = 0; i < nb; i++)
      add(0, i == nb - 1, 4'(i + 1), 4'(i + 2), 1, 0, 0, (i == nb - 1) ? serr : 1'b0, 0);
  endfunction

  // Control packet with nb data beats; nibbles beyond 9 are junk (4'hC).
  function automatic void add_ctrl(input logic [15:0] w, input logic [15:0] h,
                                   input logic [3:0] il, input int nb, input logic ok);
    logic [3:0] n[12];
    n[0] = w[15:12]; n[1] = w[11:8]; n[2] = w[7:4];  n[3] = w[3:0];
    n[4] = h[15:12]; n[5] = h[11:8]; n[6] = h[7:4];  n[7] = h[3:0];
    n[8] = il; n[9] = 4'hC; n[10] = 4'hC; n[11] = 4'hC;
    add(1, 0, 4'hF, 4'h0, 0, 0, 0, 0, 0);
    for (int b = 0; b < nb; b++) begin
      if (b == nb - 1 && ok) begin cw = w; ch = h; cil = il; end
      add(0, b == nb - 1, n[2*b], n[2*b+1], 0, (b == nb - 1) && ok, (b == nb - 1) && !ok, 0, 0);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [DW-1:0] dat);
    av.is_valid = v; av.is_sop = sop; av.is_eop = eop; av.is_data = dat;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wrreq"},    {31'd0, wrreq},       32'd0);
    chk({tag, " upd"},      {31'd0, ctrl_update}, 32'd0);
    chk({tag, " cerr"},     {31'd0, ctrl_err},    32'd0);
    chk({tag, " serr"},     {31'd0, size_err},    32'd0);
    chk({tag, " perr"},     {31'd0, pkt_err},     32'd0);
  endtask

  initial begin
    drive(0, 0, 0, '0);
    enable = 1'b1;

    // Reset state
    repeat (3) @(posedge is_clk);
    #1;
    chk("rst ready", {31'd0, av.is_ready}, 32'd0);
    chk("rst wrdata", 32'(wrdata), 32'd0);
    chk("rst width", 32'(ctrl_width), 32'd0);
    chk("rst height", 32'(ctrl_height), 32'd0);
    chk("rst il", 32'(ctrl_interlace), 32'd0);
    chk_quiet("rst");
    @(negedge is_clk) rst_n = 1'b1;
    #1 chk("ready pre-edge", {31'd0, av.is_ready}, 32'd0);
    repeat (2) @(posedge is_clk);
    #1 chk("ready after rst", {31'd0, av.is_ready}, 32'd1);
    chk_quiet("idle");

    // Ready follows enable & ~almost_full with one cycle of latency
    almost_full = 1'b1;
    #1 chk("ready af same cyc", {31'd0, av.is_ready}, 32'd1);
    @(posedge is_clk); #1 chk("ready af", {31'd0, av.is_ready}, 32'd0);
    almost_full = 1'b0;
    @(posedge is_clk); #1 chk("ready af clr", {31'd0, av.is_ready}, 32'd1);
    enable = 1'b0;
    @(posedge is_clk); #1 chk("ready dis", {31'd0, av.is_ready}, 32'd0);
    enable = 1'b1;
    @(posedge is_clk); #1 chk("ready en", {31'd0, av.is_ready}, 32'd1);

    // ---- Stimulus table ----
    // Video before any control packet: size check skipped.
    add(1, 0, 4'h0, 4'h1, 1, 0, 0, 0, 0);
    add(0, 1, 4'h1, 4'h1, 1, 0, 0, 0, 0);
    // 1920x1080 progressive control packet, hand-laid nibbles.
    add(1, 0, 4'hF, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h7, 0, 0, 0, 0, 0);
    add(0, 0, 4'h8, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h4, 0, 0, 0, 0, 0);
    add(0, 0, 4'h3, 4'h8, 0, 0, 0, 0, 0);
    cw = 16'h0780; ch = 16'h0438; cil = 4'h0;
    add(0, 1, 4'h0, 4'h9, 0, 1, 0, 0, 0);
    // Short control packet (eop on beat 3): error, values kept.
    add_ctrl(16'h0004, 16'h0002, 4'h0, 3, 0);
    // 4x2 progressive.
    add_ctrl(16'h0004, 16'h0002, 4'h0, 5, 1);
    // Stray beat in WAIT_SOP is dropped.
    add(0, 0, 4'h3, 4'h3, 0, 0, 0, 0, 0);
    add_video(4, 0);   // exact 4x2
    add_video(2, 1);   // one line short
    add_video(3, 1);   // partial last line
    // Sop mid-video: pkt_err, new header written, counters restart.
    add(1, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 0, 4'h4, 4'h4, 1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h3, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, i == 3, 4'(i), 4'(i), 1, 0, 0, 0, 0);
    // Ancillary type 5, 4 beats.
    add(1, 0, 4'h5, 4'h0, ANC_ON, 0, 0, 0, 0);
    add(0, 0, 4'h1, 4'h2, ANC_ON, 0, 0, 0, 0);
    add(0, 0, 4'h3, 4'h4, ANC_ON, 0, 0, 0, 0);
    add(0, 1, 4'h5, 4'h6, ANC_ON, 0, 0, 0, 0);
    // Control sop inside an ancillary packet, then eop on beat 1.
    add(1, 0, 4'h5, 4'h0, ANC_ON, 0, 0, 0, 0);
    add(1, 0, 4'hF, 4'h0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h0, 4'h0, 0, 0, 1, 0, 0);
    // One-beat packets.
    add(1, 1, 4'h0, 4'h5, 1, 0, 0, 0, 0);
    add(1, 1, 4'hF, 4'h0, 0, 0, 1, 0, 0);
    // Interlaced 4x4 frame: fields of 2 lines.
    add_ctrl(16'h0004, 16'h0004, 4'h8, 5, 1);
    add_video(4, 0);
    add_video(8, 1);

    @(posedge is_clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].sop, vecs[i].eop, vecs[i].data);
      @(posedge is_clk); #1;
      chk($sformatf("row%0d wrreq", i), {31'd0, wrreq}, {31'd0, vecs[i].wr});
      if (vecs[i].wr)
        chk($sformatf("row%0d wrdata", i), 32'(wrdata), 32'({vecs[i].data, vecs[i].eop}));
      chk($sformatf("row%0d upd", i),  {31'd0, ctrl_update}, {31'd0, vecs[i].upd});
      chk($sformatf("row%0d cerr", i), {31'd0, ctrl_err},    {31'd0, vecs[i].cerr});
      chk($sformatf("row%0d serr", i), {31'd0, size_err},    {31'd0, vecs[i].serr});
      chk($sformatf("row%0d perr", i), {31'd0, pkt_err},     {31'd0, vecs[i].perr});
      chk($sformatf("row%0d width", i),  32'(ctrl_width),     32'(vecs[i].w));
      chk($sformatf("row%0d height", i), 32'(ctrl_height),    32'(vecs[i].h));
      chk($sformatf("row%0d il", i),     32'(ctrl_interlace), 32'(vecs[i].il));
    end
    drive(0, 0, 0, '0);
    @(posedge is_clk); #1 chk_quiet("post table");

    // Reset mid-packet: outputs clear asynchronously, state back to WAIT_SOP.
    drive(1, 1, 0, d(4'h0, 4'h0));
    @(posedge is_clk); #1;
    drive(1, 0, 0, d(4'h1, 4'h1));
    @(posedge is_clk); #1;
    drive(0, 0, 0, '0);
    rst_n = 1'b0;
    #2;
    chk("midrst width", 32'(ctrl_width), 32'd0);
    chk("midrst il", 32'(ctrl_interlace), 32'd0);
    chk("midrst wrreq", {31'd0, wrreq}, 32'd0);
    chk("midrst ready", {31'd0, av.is_ready}, 32'd0);
    @(negedge is_clk) rst_n = 1'b1;
    repeat (2) @(posedge is_clk);
    #1 drive(1, 0, 1, d(4'h2, 4'h2));
    @(posedge is_clk); #1;
    chk("after rst stray", {31'd0, wrreq}, 32'd0);
    // Fresh reset forgets the decoded control packet: no size check.
    drive(1, 1, 0, d(4'h0, 4'h7));
    @(posedge is_clk); #1;
    chk("post rst hdr wr", {31'd0, wrreq}, 32'd1);
    drive(1, 0, 1, d(4'h3, 4'h3));
    @(posedge is_clk); #1;
    chk("post rst end", 32'(wrdata), 32'({d(4'h3, 4'h3), 1'b1}));
    chk("post rst serr", {31'd0, size_err}, 32'd0);
    drive(0, 0, 0, '0);
    repeat (2) @(posedge is_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
